// File: rtl/full_adder.sv
// full_adder
//   Single-bit full adder leaf cell. The combinational sum/carry path is the
//   primary function and depends only on a, b, cin. A clocked bit-serial path
//   reuses the same cell to add operands LSB-first, one bit per enabled cycle,
//   keeping the carry in a flop and counting processed bits.
//
// Parameters
//   CNT_W      width of the serial bit counter (wraps modulo 2^CNT_W)
// Ports
//   clk        rising-edge clock, serial path only
//   rst        synchronous active-high reset, serial path only
//   a, b       addend bits
//   cin        carry in; also seeds the serial carry on ser_start
//   ser_en     advance the serial adder one bit
//   ser_start  first bit of a new serial operation
//   sum        combinational a ^ b ^ cin
//   carry      combinational majority(a, b, cin)
//   ser_sum    registered sum bit of the last serial step
//   ser_carry  registered serial carry state
//   ser_bits   bits processed in the current serial operation
module full_adder #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a,
  input  logic             b,
  input  logic             cin,
  input  logic             ser_en,
  input  logic             ser_start,
  output logic             sum,
  output logic             carry,
  output logic             ser_sum,
  output logic             ser_carry,
  output logic [CNT_W-1:0] ser_bits
);

  logic ser_cin;
  logic ser_sum_next;
  logic ser_carry_next;

  // Combinational cell: only a, b and cin reach these outputs, so floating
  // serial controls can never disturb them.
  always_comb begin
    sum   = a ^ b ^ cin;
    carry = (a & b) | (a & cin) | (b & cin);
  end

  // Serial step: a new operation takes its carry-in from cin, otherwise the
  // carry held from the previous bit is used.
  always_comb begin
    ser_cin        = ser_start ? cin : ser_carry;
    ser_sum_next   = a ^ b ^ ser_cin;
    ser_carry_next = (a & b) | (a & ser_cin) | (b & ser_cin);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ser_sum   <= 1'b0;
      ser_carry <= 1'b0;
      ser_bits  <= '0;
    end else if (ser_en) begin
      ser_sum   <= ser_sum_next;
      ser_carry <= ser_carry_next;
      ser_bits  <= ser_start ? CNT_W'(1) : ser_bits + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_full_adder.sv
// Self-checking bench for full_adder. Two instances share all inputs: the
// default CNT_W=8 cell and a CNT_W=2 cell used for counter wrap checks.
// Expected values come from integer arithmetic on whole operands.
module tb_full_adder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       a = 1'b0, b = 1'b0, cin = 1'b0;
  logic       ser_en = 1'b0, ser_start = 1'b0;
  logic       sum, carry, ser_sum, ser_carry;
  logic [7:0] ser_bits;
  logic       sum2, carry2, ser_sum2, ser_carry2;
  logic [1:0] ser_bits2;

  int tests  = 0;
  int errors = 0;

  always #5 clk = ~clk;

  full_adder #(.CNT_W(8)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .cin(cin),
    .ser_en(ser_en), .ser_start(ser_start),
    .sum(sum), .carry(carry),
    .ser_sum(ser_sum), .ser_carry(ser_carry), .ser_bits(ser_bits)
  );

  full_adder #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .a(a), .b(b), .cin(cin),
    .ser_en(ser_en), .ser_start(ser_start),
    .sum(sum2), .carry(carry2),
    .ser_sum(ser_sum2), .ser_carry(ser_carry2), .ser_bits(ser_bits2)
  );

  task automatic test_comb_exhaustive();
    for (int v = 0; v < 8; v++) begin
      int tot;
      a   = v[2];
      b   = v[1];
      cin = v[0];
      #10;
      tot = int'(a) + int'(b) + int'(cin);
      tests++;
      if ({sum, carry} !== {tot[0], tot[1]}) begin
        errors++;
        $display("FAIL comb_tt abc=%0d%0d%0d got sum/carry=%b/%b want %b/%b",
                 a, b, cin, sum, carry, tot[0], tot[1]);
      end
      tests++;
      if ({sum2, carry2} !== {tot[0], tot[1]}) begin
        errors++;
        $display("FAIL comb_tt_w2 abc=%0d%0d%0d got %b/%b want %b/%b",
                 a, b, cin, sum2, carry2, tot[0], tot[1]);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ser_en = 1'b1;
    ser_start = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if ({ser_sum, ser_carry, ser_bits} !== 10'd0) begin
      errors++;
      $display("FAIL reset_state got sum=%b carry=%b bits=%0d want 0/0/0",
               ser_sum, ser_carry, ser_bits);
    end
    tests++;
    if ({ser_sum2, ser_carry2, ser_bits2} !== 4'd0) begin
      errors++;
      $display("FAIL reset_state_w2 got sum=%b carry=%b bits=%0d want 0/0/0",
               ser_sum2, ser_carry2, ser_bits2);
    end
    @(negedge clk);
    rst = 1'b0;
    ser_en = 1'b0;
    ser_start = 1'b0;
  endtask

  // Adds opa + opb + c0 over n bits LSB-first and checks every step against
  // the corresponding bits of the integer sum of the low operand bits.
  task automatic test_serial(input string name, input logic [31:0] opa,
                             input logic [31:0] opb, input logic c0,
                             input int n);
    for (int i = 0; i < n; i++) begin
      longint mask, tot;
      logic   es, ec;
      @(negedge clk);
      ser_en    = 1'b1;
      ser_start = (i == 0);
      a   = opa[i];
      b   = opb[i];
      cin = (i == 0) ? c0 : logic'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      mask = (longint'(1) << (i + 1)) - 1;
      tot  = (longint'(opa) & mask) + (longint'(opb) & mask) + longint'(c0);
      es   = tot[i];
      ec   = tot[i+1];
      tests++;
      if (ser_sum !== es || ser_bits !== 8'((i + 1) % 256)) begin
        errors++;
        $display("FAIL %s step %0d got ser_sum=%b bits=%0d want %b/%0d",
                 name, i, ser_sum, ser_bits, es, (i + 1) % 256);
      end
      if (i == n - 1) begin
        tests++;
        if (ser_carry !== ec || ser_bits2 !== 2'((i + 1) % 4)) begin
          errors++;
          $display("FAIL %s final got ser_carry=%b bits2=%0d want %b/%0d",
                   name, ser_carry, ser_bits2, ec, (i + 1) % 4);
        end
      end
    end
    @(negedge clk);
    ser_en = 1'b0;
    ser_start = 1'b0;
  endtask

  task automatic test_start_seed();
    @(negedge clk);
    ser_en = 1'b1; ser_start = 1'b1; a = 1'b1; b = 1'b1; cin = 1'b1;
    @(posedge clk);
    #1;
    tests++;
    if (ser_sum !== 1'b1 || ser_carry !== 1'b1 || ser_bits !== 8'd1) begin
      errors++;
      $display("FAIL start_seed got %b/%b/%0d want 1/1/1",
               ser_sum, ser_carry, ser_bits);
    end
    @(negedge clk);
    ser_en = 1'b0; ser_start = 1'b0;
  endtask

  task automatic test_hold_reset();
    logic       hs, hc;
    logic [7:0] hb;
    // Start an operation: 1+1 with cin=0, then 0+1 -> sum 0 carry 1, sum 0 carry 1
    @(negedge clk);
    ser_en = 1'b1; ser_start = 1'b1; a = 1'b1; b = 1'b1; cin = 1'b0;
    @(negedge clk);
    ser_start = 1'b0; a = 1'b1; b = 1'b0;
    @(negedge clk);
    hs = 1'b0; hc = 1'b1; hb = 8'd2;
    tests++;
    if ({ser_sum, ser_carry, ser_bits} !== {hs, hc, hb}) begin
      errors++;
      $display("FAIL hold_setup got %b/%b/%0d want %b/%b/%0d",
               ser_sum, ser_carry, ser_bits, hs, hc, hb);
    end
    ser_en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      int tot;
      a = logic'($urandom_range(0, 1));
      b = logic'($urandom_range(0, 1));
      cin = logic'($urandom_range(0, 1));
      ser_start = logic'($urandom_range(0, 1));
      #1;
      tot = int'(a) + int'(b) + int'(cin);
      tests++;
      if ({sum, carry} !== {tot[0], tot[1]}) begin
        errors++;
        $display("FAIL hold_comb cycle %0d got %b/%b want %b/%b",
                 k, sum, carry, tot[0], tot[1]);
      end
      @(posedge clk);
      #1;
      tests++;
      if ({ser_sum, ser_carry, ser_bits} !== {hs, hc, hb}) begin
        errors++;
        $display("FAIL hold cycle %0d got %b/%b/%0d want %b/%b/%0d",
                 k, ser_sum, ser_carry, ser_bits, hs, hc, hb);
      end
      @(negedge clk);
    end
    // Reset with ser_en active mid-operation; inputs would set all ones.
    ser_en = 1'b1; ser_start = 1'b0; rst = 1'b1; a = 1'b1; b = 1'b1; cin = 1'b1;
    @(posedge clk);
    #1;
    tests++;
    if ({ser_sum, ser_carry, ser_bits, ser_bits2} !== 12'd0) begin
      errors++;
      $display("FAIL mid_reset got %b/%b/%0d/%0d want 0/0/0/0",
               ser_sum, ser_carry, ser_bits, ser_bits2);
    end
    tests++;
    if ({sum, carry} !== 2'b11) begin
      errors++;
      $display("FAIL reset_comb got %b/%b want 1/1", sum, carry);
    end
    @(negedge clk);
    rst = 1'b0; ser_en = 1'b0;
  endtask

  task automatic test_counter_wrap();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      ser_en = 1'b1;
      ser_start = (k == 0);
      a = logic'($urandom_range(0, 1));
      b = logic'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      tests++;
      if (ser_bits2 !== 2'((k + 1) % 4)) begin
        errors++;
        $display("FAIL counter_wrap step %0d got %0d want %0d",
                 k, ser_bits2, (k + 1) % 4);
      end
    end
    @(negedge clk);
    ser_en = 1'b0; ser_start = 1'b0;
  endtask

  task automatic test_back_to_back();
    // Abandon a partial operation, then run random full-length ones.
    @(negedge clk);
    ser_en = 1'b1; ser_start = 1'b1; a = 1'b1; b = 1'b1; cin = 1'b1;
    @(negedge clk);
    ser_start = 1'b0;
    @(negedge clk);
    ser_en = 1'b0;
    test_serial("restart", 32'h0000_0005, 32'h0000_0003, 1'b0, 4);
    for (int r = 0; r < 6; r++) begin
      int n;
      n = $urandom_range(1, 16);
      test_serial("random", $urandom, $urandom, logic'($urandom_range(0, 1)), n);
    end
  endtask

  initial begin
    test_comb_exhaustive();
    test_reset();
    test_serial("add_7_1", 32'h7, 32'h1, 1'b0, 4);
    test_serial("ovf_15_1", 32'hF, 32'h1, 1'b0, 4);
    test_start_seed();
    test_hold_reset();
    test_counter_wrap();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
